// File: rtl/commit_ctrl.sv
// Reorder-buffer retirement controller: sequences register write-back,
// store release and mispredict flush for the head ROB entry.
module commit_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned TYPE_W = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              transmit_from_rob,
  input  logic [ROB_W-1:0]  rob_pos_from_rob,
  input  logic [REG_W-1:0]  regfile_pos_from_rob,
  input  logic [DATA_W-1:0] data_from_rob,
  input  logic [ADDR_W-1:0] jump_addr_from_rob,
  input  logic [TYPE_W-1:0] type_from_rob,
  input  logic              jump_from_rob,
  output logic              rdy_to_rob,
  output logic              we_to_regfile,
  output logic [REG_W-1:0]  waddr_to_regfile,
  output logic [DATA_W-1:0] wdata_to_regfile,
  output logic [ROB_W-1:0]  rob_pos_to_regfile,
  output logic              store_commit_to_slbuffer,
  output logic [ROB_W-1:0]  rob_pos_to_slbuffer,
  input  logic              store_done_from_slbuffer,
  output logic              flush_out,
  output logic [ADDR_W-1:0] pc_to_fetch,
  output logic [31:0]       retired_count,
  output logic [15:0]       flush_count
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SKIP       = 2'd1;
  localparam logic [1:0] ST_STORE_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH      = 2'd3;

  localparam logic [TYPE_W-1:0] TY_ALU   = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TY_JUMP  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TY_STORE = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] TY_LOAD  = TYPE_W'(3);

  logic [1:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ROB_W-1:0]  rf_pos_q, rf_pos_d;
  logic              st_commit_q, st_commit_d;
  logic [ROB_W-1:0]  sl_pos_q, sl_pos_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ret_cnt_q, ret_cnt_d;
  logic [15:0]       fl_cnt_q, fl_cnt_d;
  logic              reg_write_c;

  assign reg_write_c = (regfile_pos_from_rob != REG_W'(0));

  // Next-state and registered-output computation; pulses default low, data holds.
  always_comb begin
    state_d     = state_q;
    rdy_d       = 1'b0;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rf_pos_d    = rf_pos_q;
    st_commit_d = 1'b0;
    sl_pos_d    = sl_pos_q;
    flush_d     = 1'b0;
    pc_d        = pc_q;
    ret_cnt_d   = ret_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (transmit_from_rob) begin
            if (type_from_rob == TY_STORE) begin
              st_commit_d = 1'b1;
              sl_pos_d    = rob_pos_from_rob;
              state_d     = ST_STORE_WAIT;
            end else begin
              // ALU, LOAD and JUMP (link value) all write back
              if (reg_write_c) begin
                we_d     = 1'b1;
                waddr_d  = regfile_pos_from_rob;
                wdata_d  = data_from_rob;
                rf_pos_d = rob_pos_from_rob;
              end
              rdy_d     = 1'b1;
              ret_cnt_d = ret_cnt_q + 32'd1;
              state_d   = ST_SKIP;
              if ((type_from_rob == TY_JUMP) && jump_from_rob) begin
                flush_d  = 1'b1;
                pc_d     = jump_addr_from_rob;
                fl_cnt_d = fl_cnt_q + 16'd1;
                state_d  = ST_FLUSH;
              end
            end
          end
        end
        ST_STORE_WAIT: begin
          if (store_done_from_slbuffer) begin
            rdy_d     = 1'b1;
            ret_cnt_d = ret_cnt_q + 32'd1;
            state_d   = ST_SKIP;
          end
        end
        ST_SKIP:  state_d = ST_IDLE;
        ST_FLUSH: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rf_pos_q    <= '0;
      st_commit_q <= 1'b0;
      sl_pos_q    <= '0;
      flush_q     <= 1'b0;
      pc_q        <= '0;
      ret_cnt_q   <= '0;
      fl_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rf_pos_q    <= rf_pos_d;
      st_commit_q <= st_commit_d;
      sl_pos_q    <= sl_pos_d;
      flush_q     <= flush_d;
      pc_q        <= pc_d;
      ret_cnt_q   <= ret_cnt_d;
      fl_cnt_q    <= fl_cnt_d;
    end
  end

  assign rdy_to_rob               = rdy_q;
  assign we_to_regfile            = we_q;
  assign waddr_to_regfile         = waddr_q;
  assign wdata_to_regfile         = wdata_q;
  assign rob_pos_to_regfile       = rf_pos_q;
  assign store_commit_to_slbuffer = st_commit_q;
  assign rob_pos_to_slbuffer      = sl_pos_q;
  assign flush_out                = flush_q;
  assign pc_to_fetch              = pc_q;
  assign retired_count            = ret_cnt_q;
  assign flush_count              = fl_cnt_q;

  // The TY_ALU / TY_LOAD codes share the write-back path above.
  logic unused_types_c;
  assign unused_types_c = (TY_ALU == TY_LOAD);

endmodule
